// File: rtl/ext_mem_port_mc.sv
// Multi-channel external-memory port: boot preamble on load channel 0, NUM_CH fixed-latency
// load channels with back-pressure, one store channel. FTk = {v,a,r,c,i[WIDTH_A],d[WIDTH_D]}, BTk = {n}.
module ext_mem_port_mc #(
  parameter int WIDTH_D  = 32,
  parameter int WIDTH_A  = 10,
  parameter int DEPTH    = 1024,
  parameter int NUM_CH   = 2,
  parameter int RD_LAT   = 1,
  parameter int BOOT_PAD = 3,
  parameter int BOOT_LEN = 5,
  parameter int IDX_MODE = 0
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  I_Boot,
  output logic                                  O_Busy,
  input  logic [NUM_CH-1:0]                     I_Ld_Req,
  input  logic [NUM_CH*WIDTH_A-1:0]             I_Ld_Addr,
  output logic [NUM_CH*(WIDTH_D+WIDTH_A+4)-1:0] O_Ld_FTk,
  input  logic [NUM_CH-1:0]                     I_Ld_BTk,
  input  logic                                  I_St_Req,
  input  logic [WIDTH_A-1:0]                    I_St_Addr,
  input  logic [WIDTH_D+WIDTH_A+3:0]            I_St_FTk,
  output logic                                  O_St_BTk,
  output logic [NUM_CH-1:0]                     O_Err,
  input  logic [WIDTH_A-1:0]                    I_Dbg_Addr,
  output logic [WIDTH_D-1:0]                    O_Dbg_Data
);

  localparam int FTK_W = WIDTH_D + WIDTH_A + 4;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PAD = 2'd1, S_IMG = 2'd2} state_t;

  logic [WIDTH_D-1:0] mem [DEPTH];

  function automatic logic in_range(input logic [WIDTH_A-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  function automatic logic [WIDTH_D-1:0] rd_word(input logic [WIDTH_A-1:0] a);
    return in_range(a) ? mem[a] : '0;
  endfunction

  // Store port: memory is never reset; reads elsewhere see the pre-edge contents.
  always_ff @(posedge clock) begin
    if (I_St_Req && I_St_FTk[FTK_W-1] && in_range(I_St_Addr))
      mem[I_St_Addr] <= I_St_FTk[WIDTH_D-1:0];
  end

  assign O_St_BTk = 1'b0;

  logic unused_st_bits;
  assign unused_st_bits = ^I_St_FTk[FTK_W-2:WIDTH_D];

  state_t             state, state_nxt;
  logic [15:0]        cnt, cnt_nxt;
  logic               btk_v, btk_a, btk_v_nxt, btk_a_nxt;
  logic [WIDTH_D-1:0] btk_d, btk_d_nxt;
  logic               boot_stall;

  assign O_Busy     = (state != S_IDLE);
  assign boot_stall = I_Ld_BTk[0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      btk_v <= 1'b0;
      btk_a <= 1'b0;
      btk_d <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      btk_v <= btk_v_nxt;
      btk_a <= btk_a_nxt;
      btk_d <= btk_d_nxt;
    end
  end

  // The boot token is registered so a stalled word cannot change under a concurrent store.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    btk_v_nxt = btk_v;
    btk_a_nxt = btk_a;
    btk_d_nxt = btk_d;
    case (state)
      S_IDLE: begin
        if (I_Boot) begin
          cnt_nxt   = '0;
          btk_v_nxt = 1'b1;
          if (BOOT_PAD > 0) begin
            state_nxt = S_PAD;
            btk_a_nxt = 1'b1;
            btk_d_nxt = '0;
          end else begin
            state_nxt = S_IMG;
            btk_a_nxt = 1'b0;
            btk_d_nxt = rd_word('0);
          end
        end
      end
      S_PAD: begin
        if (!boot_stall) begin
          btk_a_nxt = 1'b0;
          if (cnt == 16'(BOOT_PAD - 1)) begin
            state_nxt = S_IMG;
            cnt_nxt   = '0;
            btk_d_nxt = rd_word('0);
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
      end
      S_IMG: begin
        if (!boot_stall) begin
          if (cnt == 16'(BOOT_LEN - 1)) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            btk_v_nxt = 1'b0;
            btk_d_nxt = '0;
          end else begin
            cnt_nxt   = cnt + 16'd1;
            btk_d_nxt = rd_word(WIDTH_A'(cnt + 16'd1));
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) O_Dbg_Data <= '0;
    else        O_Dbg_Data <= rd_word(I_Dbg_Addr);
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [RD_LAT-1:0]  vld_p;
    logic [WIDTH_D-1:0] dat_p [RD_LAT];
    logic [WIDTH_A-1:0] idx_p [RD_LAT];
    logic [WIDTH_A-1:0] addr;
    logic               own, req, stall, err_q;

    // While booting, channel 0's output belongs to the boot token; its pipeline just drains.
    assign own   = (ch == 0) && O_Busy;
    assign addr  = I_Ld_Addr[ch*WIDTH_A +: WIDTH_A];
    assign req   = I_Ld_Req[ch] && !own;
    assign stall = vld_p[RD_LAT-1] && I_Ld_BTk[ch] && !own;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        vld_p <= '0;
        err_q <= 1'b0;
        for (int k = 0; k < RD_LAT; k++) begin
          dat_p[k] <= '0;
          idx_p[k] <= '0;
        end
      end else if (!stall) begin
        vld_p[0] <= req;
        dat_p[0] <= rd_word(addr);
        idx_p[0] <= (IDX_MODE != 0) ? addr : '0;
        for (int k = 1; k < RD_LAT; k++) begin
          vld_p[k] <= vld_p[k-1];
          dat_p[k] <= dat_p[k-1];
          idx_p[k] <= idx_p[k-1];
        end
      end else if (req) begin
        err_q <= 1'b1;
      end
    end

    assign O_Err[ch] = err_q;
    assign O_Ld_FTk[ch*FTK_W +: FTK_W] = own
      ? {btk_v, btk_a, 2'b00, {WIDTH_A{1'b0}}, btk_d}
      : {vld_p[RD_LAT-1], 3'b000, idx_p[RD_LAT-1], dat_p[RD_LAT-1]};
  end

endmodule

// File: tb/tb_ext_mem_port_mc.sv
// Directed bench for ext_mem_port_mc: one DUT with RD_LAT=2/IDX_MODE=1 (a), one with defaults (b),
// sharing all inputs.
module tb_ext_mem_port_mc;

  localparam int FW = 46;

  logic        clock, reset, boot;
  logic [1:0]  ld_req, ld_btk;
  logic [19:0] ld_addr;
  logic        st_req;
  logic [9:0]  st_addr, dbg_addr;
  logic [45:0] st_ftk;

  logic        busy_a, busy_b, stb_a, stb_b;
  logic [91:0] ftk_a, ftk_b;
  logic [1:0]  err_a, err_b;
  logic [31:0] dbg_a, dbg_b;

  int n_chk = 0;
  int n_fail = 0;

  ext_mem_port_mc #(.RD_LAT(2), .IDX_MODE(1)) dut_a (
    .clock(clock), .reset(reset), .I_Boot(boot), .O_Busy(busy_a),
    .I_Ld_Req(ld_req), .I_Ld_Addr(ld_addr), .O_Ld_FTk(ftk_a), .I_Ld_BTk(ld_btk),
    .I_St_Req(st_req), .I_St_Addr(st_addr), .I_St_FTk(st_ftk), .O_St_BTk(stb_a),
    .O_Err(err_a), .I_Dbg_Addr(dbg_addr), .O_Dbg_Data(dbg_a));

  ext_mem_port_mc dut_b (
    .clock(clock), .reset(reset), .I_Boot(boot), .O_Busy(busy_b),
    .I_Ld_Req(ld_req), .I_Ld_Addr(ld_addr), .O_Ld_FTk(ftk_b), .I_Ld_BTk(ld_btk),
    .I_St_Req(st_req), .I_St_Addr(st_addr), .I_St_FTk(st_ftk), .O_St_BTk(stb_b),
    .O_Err(err_b), .I_Dbg_Addr(dbg_addr), .O_Dbg_Data(dbg_b));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic fv(input logic [91:0] f, input int ch);
    logic [45:0] t;
    t = f[ch*FW +: FW];
    return t[45];
  endfunction
  function automatic logic fa(input logic [91:0] f, input int ch);
    logic [45:0] t;
    t = f[ch*FW +: FW];
    return t[44];
  endfunction
  function automatic logic [9:0] fi(input logic [91:0] f, input int ch);
    logic [45:0] t;
    t = f[ch*FW +: FW];
    return t[41:32];
  endfunction
  function automatic logic [31:0] fd(input logic [91:0] f, input int ch);
    logic [45:0] t;
    t = f[ch*FW +: FW];
    return t[31:0];
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic store(input logic [9:0] a, input logic [31:0] d, input logic v);
    st_req = 1'b1; st_addr = a; st_ftk = {v, 3'b000, 10'd0, d};
    next_cycle();
    st_req = 1'b0; st_ftk = '0;
  endtask

  // Boot model: 3 pad words (a=1 on the first), then A0..A4; a stalled cycle repeats its word.
  task automatic boot_run(input int stall_j, input int abort_j);
    int w, seen;
    logic [31:0] ed;
    w = 0; seen = 0;
    boot = 1'b1;
    next_cycle();
    boot = 1'b0; ld_req[0] = 1'b1; ld_addr[9:0] = 10'd3;
    for (int j = 1; j <= 12; j++) begin
      if (j == abort_j) begin
        reset = 1'b0;
        #1;
        chk("abort_busy_a", 96'(busy_a), 96'd0);
        chk("abort_busy_b", 96'(busy_b), 96'd0);
        chk("abort_ftk_a", 96'(ftk_a), 96'd0);
        chk("abort_ftk_b", 96'(ftk_b), 96'd0);
        chk("abort_err_a", 96'(err_a), 96'd0);
        ld_req = '0; ld_btk = '0; boot = 1'b0;
        next_cycle();
        reset = 1'b1;
        return;
      end
      boot = (j == 2);
      if (w == 8) begin
        chk("boot_end_v_a", 96'(fv(ftk_a, 0)), 96'd0);
        chk("boot_end_v_b", 96'(fv(ftk_b, 0)), 96'd0);
        chk("boot_end_busy_a", 96'(busy_a), 96'd0);
        chk("boot_end_busy_b", 96'(busy_b), 96'd0);
        chk("boot_words", 96'(seen), 96'd8);
        ld_req[0] = 1'b0; ld_btk[0] = 1'b0;
        next_cycle();
        chk("post_boot_v_a", 96'(fv(ftk_a, 0)), 96'd0);
        chk("post_boot_v_b", 96'(fv(ftk_b, 0)), 96'd0);
        chk("post_boot_err_a0", 96'(err_a[0]), 96'd0);
        return;
      end
      ed = (w < 3) ? 32'h0 : (32'hA000_0000 + 32'(w - 3));
      chk($sformatf("boot_v_a_j%0d", j), 96'(fv(ftk_a, 0)), 96'd1);
      chk($sformatf("boot_a_a_j%0d", j), 96'(fa(ftk_a, 0)), 96'(w == 0));
      chk($sformatf("boot_d_a_j%0d", j), 96'(fd(ftk_a, 0)), 96'(ed));
      chk($sformatf("boot_i_a_j%0d", j), 96'(fi(ftk_a, 0)), 96'd0);
      chk($sformatf("boot_d_b_j%0d", j), 96'(fd(ftk_b, 0)), 96'(ed));
      chk($sformatf("boot_busy_a_j%0d", j), 96'(busy_a), 96'd1);
      ld_btk[0] = (j == stall_j);
      if (fv(ftk_a, 0) && !ld_btk[0]) seen++;
      if (j != stall_j) w++;
      next_cycle();
    end
    n_chk++; n_fail++;
    $display("FAIL boot_timeout: got %0d words, want 8", w);
  endtask

  typedef struct packed {
    logic        req;
    logic [9:0]  addr;
    logic        n;
    logic        ev;
    logic [31:0] ed;
    logic [9:0]  ei;
    logic        eerr;
  } vec_t;

  vec_t vecs [14];

  initial begin
    reset = 1'b1; boot = 1'b0; ld_req = '0; ld_btk = '0; ld_addr = '0;
    st_req = 1'b0; st_addr = '0; st_ftk = '0; dbg_addr = '0;
    #1 reset = 1'b0;
    next_cycle();
    next_cycle();
    chk("rst_busy_a", 96'(busy_a), 96'd0);
    chk("rst_ftk_a", 96'(ftk_a), 96'd0);
    chk("rst_ftk_b", 96'(ftk_b), 96'd0);
    chk("rst_err_a", 96'(err_a), 96'd0);
    chk("rst_dbg_a", 96'(dbg_a), 96'd0);
    chk("rst_stbtk_a", 96'(stb_a), 96'd0);
    reset = 1'b1;

    for (int k = 0; k < 5; k++) store(10'(k), 32'hA000_0000 + 32'(k), 1'b1);
    for (int k = 5; k < 10; k++) store(10'(k), 32'hB000_0000 + 32'(k), 1'b1);
    store(10'd5, 32'h1234_5678, 1'b0);

    // Plain boot with a re-pulse during PAD and ch0 requests that must be ignored
    boot_run(-1, -1);

    // RD_LAT=2 back-to-back loads on ch1, then a 3-cycle stall with a dropped request
    vecs[0]  = '{1'b1, 10'd5, 1'b0, 1'b0, 32'h0, 10'd0, 1'b0};
    vecs[1]  = '{1'b1, 10'd6, 1'b0, 1'b0, 32'h0, 10'd0, 1'b0};
    vecs[2]  = '{1'b1, 10'd7, 1'b0, 1'b1, 32'hB000_0005, 10'd5, 1'b0};
    vecs[3]  = '{1'b0, 10'd0, 1'b0, 1'b1, 32'hB000_0006, 10'd6, 1'b0};
    vecs[4]  = '{1'b0, 10'd0, 1'b0, 1'b1, 32'hB000_0007, 10'd7, 1'b0};
    vecs[5]  = '{1'b0, 10'd0, 1'b1, 1'b0, 32'h0, 10'd0, 1'b0};
    vecs[6]  = '{1'b1, 10'd8, 1'b0, 1'b0, 32'h0, 10'd0, 1'b0};
    vecs[7]  = '{1'b0, 10'd0, 1'b0, 1'b0, 32'h0, 10'd0, 1'b0};
    vecs[8]  = '{1'b0, 10'd0, 1'b1, 1'b1, 32'hB000_0008, 10'd8, 1'b0};
    vecs[9]  = '{1'b1, 10'd5, 1'b1, 1'b1, 32'hB000_0008, 10'd8, 1'b0};
    vecs[10] = '{1'b0, 10'd0, 1'b1, 1'b1, 32'hB000_0008, 10'd8, 1'b1};
    vecs[11] = '{1'b0, 10'd0, 1'b0, 1'b1, 32'hB000_0008, 10'd8, 1'b1};
    vecs[12] = '{1'b0, 10'd0, 1'b0, 1'b0, 32'h0, 10'd0, 1'b1};
    vecs[13] = '{1'b0, 10'd0, 1'b0, 1'b0, 32'h0, 10'd0, 1'b1};
    for (int c = 0; c < 14; c++) begin
      chk($sformatf("ld1_v_c%0d", c), 96'(fv(ftk_a, 1)), 96'(vecs[c].ev));
      if (vecs[c].ev) begin
        chk($sformatf("ld1_d_c%0d", c), 96'(fd(ftk_a, 1)), 96'(vecs[c].ed));
        chk($sformatf("ld1_i_c%0d", c), 96'(fi(ftk_a, 1)), 96'(vecs[c].ei));
      end
      chk($sformatf("ld1_err_c%0d", c), 96'(err_a[1]), 96'(vecs[c].eerr));
      ld_req[1] = vecs[c].req; ld_addr[19:10] = vecs[c].addr; ld_btk[1] = vecs[c].n;
      next_cycle();
    end
    ld_req = '0; ld_btk = '0;

    // Latency 1 and IDX_MODE=0 on the default instance
    ld_req[1] = 1'b1; ld_addr[19:10] = 10'd6;
    next_cycle();
    ld_req[1] = 1'b0;
    chk("b_lat1_v", 96'(fv(ftk_b, 1)), 96'd1);
    chk("b_lat1_d", 96'(fd(ftk_b, 1)), 96'hB000_0006);
    chk("b_lat1_i", 96'(fi(ftk_b, 1)), 96'd0);
    chk("a_lat2_early_v", 96'(fv(ftk_a, 1)), 96'd0);
    next_cycle();
    chk("b_lat1_gone_v", 96'(fv(ftk_b, 1)), 96'd0);
    chk("a_lat2_v", 96'(fv(ftk_a, 1)), 96'd1);
    chk("a_lat2_i", 96'(fi(ftk_a, 1)), 96'd6);

    // Same-cycle store and load to addr 9: read-before-write
    st_req = 1'b1; st_addr = 10'd9; st_ftk = {1'b1, 3'b000, 10'd0, 32'hDEAD_BEEF};
    ld_req[0] = 1'b1; ld_addr[9:0] = 10'd9; dbg_addr = 10'd9;
    next_cycle();
    st_req = 1'b0; st_ftk = '0;
    chk("rbw_dbg_old", 96'(dbg_a), 96'hB000_0009);
    chk("rbw_b_old", 96'(fd(ftk_b, 0)), 96'hB000_0009);
    next_cycle();
    ld_req[0] = 1'b0;
    chk("rbw_a_old_v", 96'(fv(ftk_a, 0)), 96'd1);
    chk("rbw_a_old", 96'(fd(ftk_a, 0)), 96'hB000_0009);
    chk("rbw_b_new", 96'(fd(ftk_b, 0)), 96'hDEAD_BEEF);
    chk("rbw_dbg_new", 96'(dbg_a), 96'hDEAD_BEEF);
    chk("rbw_dbg_new_b", 96'(dbg_b), 96'hDEAD_BEEF);
    next_cycle();
    chk("rbw_a_new", 96'(fd(ftk_a, 0)), 96'hDEAD_BEEF);
    next_cycle();

    // Boot with a one-cycle stall on the second image word
    boot_run(5, -1);

    // Reset while image word 2 is on the output, then verify memory and a full re-boot
    boot_run(-1, 6);
    dbg_addr = 10'd2;
    next_cycle();
    chk("mem_kept_2", 96'(dbg_a), 96'hA000_0002);
    dbg_addr = 10'd9;
    next_cycle();
    chk("mem_kept_9", 96'(dbg_a), 96'hDEAD_BEEF);
    boot_run(-1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
